serial_frame_arbiter: RTL
=========================

# serial_frame_arbiter

Shares the single-bit serial link feeding the 8-bit serial-to-parallel receiver among N_REQ requesters. Each requester offers a 4-bit address and 4-bit data nibble. The block arbitrates round-robin and serialises the winning frame LSB-first with the framing the receiver expects. After link start it streams frames back-to-back with no gaps, inserting null frames when nobody requests, so receiver bit alignment is never lost.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- NULL_ADDR, 4'h0: address sent in filler frames; its data nibble is 4'h0. Downstream ignores this address.

- clk  in  1  rising-edge clock, shared with the receiver.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  request per requester; held until granted.
- addr_in  in  4*N_REQ  address nibble; requester i uses bits [4i+3:4i].
- data_in  in  4*N_REQ  data nibble; same packing as addr_in.
- gnt  out  N_REQ  one-hot, one-cycle pulse when requester i's frame is latched.
- ena_out  out  1  link-start strobe to the receiver's ena.
- s_out  out  1  serial data to the receiver's p_in.
- busy  out  1  high once the link has started, until reset.

## Operation
- Frame word is {addr, data}, 8 bits. It is sent bit 0 first (data[0]) through bit 7 last (addr[3]).
- States:
  - IDLE: s_out=0, ena_out=0, busy=0.
  - Any req high → load frame, go to RUN.
- RUN: 3-bit bit counter bcnt, 0..7 then wraps to 0.
  - Each cycle: s_out = shreg[0], shreg shifts right by one.
  - When bcnt==7, the next frame loads so its bit 0 follows with no gap.
- Load event (IDLE exit, or bcnt==7 in RUN):
  - If any req: the winner's {addr,data} loads and its gnt pulses the cycle after the load edge.
  - Otherwise the null frame {NULL_ADDR,4'h0} loads and no gnt pulses.
- Round-robin: search starts at (last winner + 1) mod N_REQ. After reset, last winner = N_REQ-1, so requester 0 has first priority.
- A req that drops before a load event is not granted. req is sampled only at load events.
- RUN never returns to IDLE except through reset; the receiver needs continuous frames.
- Reset mid-frame: all outputs and state clear asynchronously and the partial frame is abandoned. The next request restarts the link with a fresh ena_out pulse. Re-aligning the receiver is the system's responsibility.

## Timing
- Reset values: s_out=0, ena_out=0, gnt=0, busy=0, bcnt=0, shreg=0, last winner=N_REQ-1.
- Cycle L is the IDLE→RUN load edge. At L+1:
  - ena_out=1 for exactly one cycle.
  - s_out = bit 0 of frame 1.
  - busy=1.
  - gnt pulses.
- Frame k occupies cycles L+1+8(k-1) .. L+8k. The receiver presents frame k on addr_out/data_out one edge after its last bit is sampled.
- Back-to-back requests from the same requester: at most one grant per 8 cycles, and never two consecutive grants while another req is high.
- Grant latency from req rising in RUN: at most 8·N_REQ cycles.

## Configuration
- SERIAL_ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority (lowest index wins) and the last-winner register is omitted. When undefined, round-robin as above. Framing and timing are identical either way.

## Structure
- serial_arb_pkg:
  - FRAME_BITS=8, NIBBLE_W=4.
  - typedef frame_t as a packed {addr, data} struct.
  - State enum {IDLE, RUN}.
- Sub-module rr_arbiter: combinational N_REQ-way round-robin/fixed-priority pick from req and the last-winner pointer. Outputs one-hot grant plus a valid flag. This is the only sub-module.

## Test plan
- Single request: req=4'b0001, addr0=4'hA, data0=4'h5.
  - ena_out pulses at L+1.
  - s_out over L+1..L+8 = 1,0,1,0,0,1,0,1.
  - gnt=0001 once.
  - Null frames follow.
- All four requesting continuously: grants in order 0,1,2,3,0, spaced exactly 8 cycles apart. With SERIAL_ARB_FIXED_PRIO_EN, requester 0 wins every frame.
- Gaps: req drops after one frame.
  - s_out carries {NULL_ADDR,0} frames with no idle cycles.
  - bcnt never stalls; ena_out never re-pulses.
- Receiver in loop: send frames 0x3C then 0x7E. The receiver shows addr_out=3, data_out=C, then 7/E, at the expected 8-cycle offsets.
- Reset asserted at bcnt=4: all outputs are 0 immediately. A new req restarts with an ena_out pulse and a full frame.
- Glitch request: req2 pulses between load events → no gnt to requester 2.

Source files
------------

// File: rtl/serial_arb_pkg.sv
// serial_arb_pkg
//   Shared types and constants for the serial frame arbiter.
//   FRAME_BITS : bits per serial frame ({addr, data})
//   NIBBLE_W   : width of the address and data nibbles
//   frame_t    : packed frame word, addr in the upper nibble
//   state_t    : link state, IDLE before the first frame, RUN afterwards
package serial_arb_pkg;

  localparam int FRAME_BITS = 8;
  localparam int NIBBLE_W   = 4;

  typedef struct packed {
    logic [NIBBLE_W-1:0] addr;
    logic [NIBBLE_W-1:0] data;
  } frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_frame_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational N_REQ-way pick. Round-robin by default, searching from
//   (last + 1) mod N_REQ. With SERIAL_ARB_FIXED_PRIO_EN defined the lowest
//   requesting index wins and 'last' is ignored.
//   Ports:
//     req   in  N_REQ  request vector
//     last  in  PTR_W  index of the previous winner
//     gnt   out N_REQ  one-hot winner (zero when nobody requests)
//     idx   out PTR_W  binary index of the winner
//     valid out 1      at least one request present
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  int         cand;
  logic [PTR_W-1:0] cand_p;
  logic       found;

`ifdef SERIAL_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;
`endif

  assign valid = |req;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    cand_p = '0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef SERIAL_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = (int'(last) + 1 + k) % N_REQ;
`endif
      cand_p = cand[PTR_W-1:0];
      if (!found && req[cand_p]) begin
        found       = 1'b1;
        gnt[cand_p] = 1'b1;
        idx         = cand_p;
      end
    end
  end

endmodule

// File: rtl/serial_frame_arbiter.sv
// serial_frame_arbiter
//   Shares one serial link into an 8-bit serial-to-parallel receiver among
//   N_REQ requesters. Frames {addr, data} are sent LSB first, back-to-back;
//   null frames {NULL_ADDR, 4'h0} fill slots nobody claims.
//   Build option: SERIAL_ARB_FIXED_PRIO_EN selects fixed priority (lowest
//   index wins) and drops the last-winner register.
//   Ports:
//     clk      in  1        rising-edge clock
//     rst_n    in  1        asynchronous active-low reset
//     req      in  N_REQ    request per requester, held until granted
//     addr_in  in  4*N_REQ  address nibble, requester i at [4i+3:4i]
//     data_in  in  4*N_REQ  data nibble, same packing
//     gnt      out N_REQ    one-hot grant pulse, cycle after frame load
//     ena_out  out 1        one-cycle link-start strobe
//     s_out    out 1        serial data
//     busy     out 1        link running
//
//   state | meaning
//   IDLE  | link not started, outputs quiet, waiting for any request
//   RUN   | streaming frames forever; load next frame when bcnt == 7
module serial_frame_arbiter
  import serial_arb_pkg::*;
#(
  parameter int         N_REQ     = 4,
  parameter logic [3:0] NULL_ADDR = 4'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] addr_in,
  input  logic [4*N_REQ-1:0] data_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               ena_out,
  output logic               s_out,
  output logic               busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [2:0] BCNT_LAST = 3'(FRAME_BITS - 1);

  state_t                  state_q, state_d;
  logic [2:0]              bcnt_q;
  logic [FRAME_BITS-1:0]   shreg_q;
  logic [N_REQ-1:0]        gnt_q;
  logic                    ena_q;
  logic                    load, start;
  logic [PTR_W-1:0]        last_w;
  logic [N_REQ-1:0]        arb_gnt;
  logic [PTR_W-1:0]        arb_idx;
  logic                    arb_valid;
  frame_t                  win_frame;
  frame_t                  null_frame;

  assign null_frame = '{addr: NULL_ADDR, data: 4'h0};

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req   (req),
    .last  (last_w),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

`ifdef SERIAL_ARB_FIXED_PRIO_EN
  assign last_w = '0;
`else
  logic [PTR_W-1:0] last_q;
  assign last_w = last_q;

  // Pointer starts at N_REQ-1 so requester 0 has first priority after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PTR_W'(N_REQ - 1);
    end else if (load && arb_valid) begin
      last_q <= arb_idx;
    end
  end
`endif

  always_comb begin
    win_frame = null_frame;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_frame = {addr_in[4*i +: 4], data_in[4*i +: 4]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RUN has no exit; the receiver relies on an unbroken frame stream.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = RUN;
          load    = 1'b1;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (bcnt_q == BCNT_LAST) begin
          load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      shreg_q <= '0;
      gnt_q   <= '0;
      ena_q   <= 1'b0;
    end else begin
      ena_q <= start;
      gnt_q <= '0;
      if (load) begin
        bcnt_q <= '0;
        if (arb_valid) begin
          shreg_q <= win_frame;
          gnt_q   <= arb_gnt;
        end else begin
          shreg_q <= null_frame;
        end
      end else if (state_q == RUN) begin
        shreg_q <= shreg_q >> 1;
        bcnt_q  <= bcnt_q + 3'd1;
      end
    end
  end

  assign gnt     = gnt_q;
  assign ena_out = ena_q;
  assign s_out   = (state_q == RUN) & shreg_q[0];
  assign busy    = (state_q == RUN);

endmodule
